laji_stat_display: RTL and testbench
====================================

Name: laji_stat_display

Overview:
Board-level consumer sitting directly downstream of the pipelined CPU top. It takes the CPU's retirement and control-flow status outputs (halt, is_jump, is_branch, branched, valid_inst) and counts cycles, jumps, branches, taken branches and retired instructions until halt. A view selector picks one 32-bit value: one of these counters, the syscall display word, or a debug bus. That value is scanned onto an 8-digit, active-low, multiplexed hex 7-segment display.

Parameters:
SCAN_DIV, 17, width of the free-running scan divider. Digit index is divider[SCAN_DIV-1:SCAN_DIV-3].
CNT_W, 32, width of each statistics counter. Must be ≤32; the value is zero-extended to 32 bits for display.

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
en  in  1  CPU step enable, the same signal that drives the CPU en
halt  in  1  CPU halt, registered at write-back
is_jump  in  1  DM-stage instruction is a jump
is_branch  in  1  DM-stage instruction is a conditional branch
branched  in  1  DM-stage branch taken
valid_inst  in  1  write-back stage holds a real instruction
display  in  32  syscall display word
pc_dbg  in  32  CPU PC debug value
regfile_data_dbg  in  32  register-file debug read data
view_sel  in  3  display source select
halted  out  1  sticky halt flag
seg_n  out  8  {dp,g,f,e,d,c,b,a}, active low
an_n  out  8  digit enables, active low, bit i = digit i (digit 0 rightmost)

Behaviour:
- Reset (asynchronous, rst_n=0):
  - halted=0; all counters=0; shadow=0; divider=0.
  - an_n=8'hFE; seg_n=8'hC0 (digit "0", dp off).
  - Reset mid-scan or mid-count returns to this state immediately.
- Live condition: live = en && !halted. Counters change only on rising clk when live.
- Halt flag:
  - halted is set on the clock where en && halt.
  - It is sticky until reset.
  - Counters do update on that same halt edge; they are frozen from the following edge onward.
- Counters, all saturating at all-ones (no wrap):
  - cyc_cnt: +1 every live edge.
  - jmp_cnt: +1 when live && is_jump.
  - br_cnt: +1 when live && is_branch.
  - tkn_cnt: +1 when live && is_branch && branched. branched without is_branch is ignored.
  - ret_cnt: +1 when live && valid_inst.
  - Simultaneous events on one edge each increment their own counter independently.
- View mux (combinational) selects by view_sel:
  - 0 display; 1 cyc_cnt; 2 jmp_cnt; 3 br_cnt; 4 tkn_cnt; 5 ret_cnt; 6 pc_dbg; 7 regfile_data_dbg.
  - Counters are zero-extended to 32 bits.
- Shadow register:
  - Loaded from the view mux on the edge where divider == all-ones (frame end), every frame regardless of en and halted.
  - Prevents digit tearing. Display latency is at most 2^SCAN_DIV cycles.
- Scan:
  - The divider increments every clock, ignoring en, and wraps to 0.
  - d = divider top 3 bits.
  - an_n = ~(8'b1 << d), registered so it tracks divider.
  - Nibble = shadow[4d+3:4d].
- Segment decode, active low {g..a}:
  - 0:40, 1:79, 2:24, 3:30, 4:19, 5:12, 6:02, 7:78, 8:00, 9:10, A:08, b:03, C:46, d:21, E:06, F:0E.
- dp_n = !(halted && d==0): the dp on digit 0 lights while halted.
- Outputs are glitch-free: seg_n and an_n are registered, and update on the same edge.

Test Plan:
- Reset, then run 10 cycles with en=1 and all status inputs=0 → cyc_cnt=10; jmp/br/tkn/ret=0; an_n=8'hFE at reset, seg_n=8'hC0.
- en toggling 1,0,1,0 for 8 cycles with valid_inst=1 → cyc_cnt=4, ret_cnt=4. Then halt=1 with en=1 → halted=1, cyc_cnt=5; 20 more cycles → cyc_cnt stays 5.
- Pulse is_branch=1 with branched alternating 1/0 over 6 live cycles, plus branched=1 with is_branch=0 once → br_cnt=6, tkn_cnt=3; is_jump pulsed 2× → jmp_cnt=2.
- SCAN_DIV=4, view_sel=0, display=32'h1234ABCD → after the first frame end, digit 0 shows seg_n=8'hA1 ("d"), digit 7 shows seg_n=8'hF9 ("1"); an_n cycles FE,FD,…,7F every 2 clocks.
- SCAN_DIV=4, halted=1 → seg_n[7]=0 only while an_n=8'hFE. Change view_sel mid-frame → digits keep the old value until the frame end, then update.
- CNT_W=4: run 20 live cycles → cyc_cnt saturates at 4'hF. Assert rst_n=0 mid-frame → all counters 0, an_n=8'hFE immediately (asynchronous).

Source files
------------

// File: rtl/laji_stat_display.sv
// laji_stat_display: CPU run statistics counters shown on an 8-digit multiplexed active-low hex display
module laji_stat_display #(
    parameter int SCAN_DIV = 17,
    parameter int CNT_W = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic        halt,
    input  logic        is_jump,
    input  logic        is_branch,
    input  logic        branched,
    input  logic        valid_inst,
    input  logic [31:0] display,
    input  logic [31:0] pc_dbg,
    input  logic [31:0] regfile_data_dbg,
    input  logic [2:0]  view_sel,
    output logic        halted,
    output logic [7:0]  seg_n,
    output logic [7:0]  an_n
);
    localparam logic [6:0] SEG [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    logic                live;
    logic                halted_nx;
    logic [4:0]          inc;
    logic [CNT_W-1:0]    cnt [5];
    logic [31:0]         views [8];
    logic [31:0]         shadow;
    logic [31:0]         shadow_nx;
    logic [SCAN_DIV-1:0] divider;
    logic [SCAN_DIV-1:0] div_nx;
    logic [2:0]          d_nx;
    logic [3:0]          nib;
    assign live      = en && !halted;
    assign halted_nx = halted || (en && halt);
    // counter order: cycles, jumps, branches, taken branches, retired
    assign inc       = {5{live}} & {valid_inst, is_branch && branched, is_branch, is_jump, 1'b1};
    assign views     = '{display, 32'(cnt[0]), 32'(cnt[1]), 32'(cnt[2]), 32'(cnt[3]), 32'(cnt[4]),
                         pc_dbg, regfile_data_dbg};
    assign div_nx    = divider + SCAN_DIV'(1);
    assign shadow_nx = &divider ? views[view_sel] : shadow;
    assign d_nx      = div_nx[SCAN_DIV-1 -: 3];
    assign nib       = shadow_nx[{d_nx, 2'b00} +: 4];
    // outputs are built from next-state values so they line up with the registers they describe
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            halted  <= 1'b0;
            divider <= '0;
            shadow  <= '0;
            an_n    <= 8'hFE;
            seg_n   <= 8'hC0;
            for (int i = 0; i < 5; i++) cnt[i] <= '0;
        end else begin
            halted  <= halted_nx;
            divider <= div_nx;
            shadow  <= shadow_nx;
            an_n    <= ~(8'b1 << d_nx);
            seg_n   <= {!(halted_nx && d_nx == 3'd0), SEG[nib]};
            for (int i = 0; i < 5; i++)
                if (inc[i] && !(&cnt[i])) cnt[i] <= cnt[i] + CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_laji_stat_display.sv
// tb_laji_stat_display: directed bench reading counters back through the scanned 7-segment display
module tb_laji_stat_display;
    localparam logic [6:0] SEGT [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                         7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    typedef struct {
        bit          use1;
        bit          hlt;
        logic [2:0]  sel;
        logic [31:0] val;
    } exp_t;
    logic        clk = 0;
    logic        rst_n = 0;
    logic        en = 0, halt = 0, is_jump = 0, is_branch = 0, branched = 0, valid_inst = 0;
    logic [31:0] display = 32'h1234ABCD;
    logic [31:0] pc_dbg = 32'h89ABCDEF;
    logic [31:0] regfile_data_dbg = 32'h0BADF00D;
    logic [2:0]  view_sel = 0;
    logic        halted0, halted1;
    logic [7:0]  seg0, seg1, an0, an1;
    logic [7:0]  seg_m, an_m;
    bit          use1 = 0;
    int          n_chk = 0;
    int          n_fail = 0;
    exp_t        exp_q[$];
    logic [31:0] v;
    logic [63:0] segs;
    laji_stat_display #(.SCAN_DIV(4), .CNT_W(32)) u0 (
        .clk(clk), .rst_n(rst_n), .en(en), .halt(halt), .is_jump(is_jump), .is_branch(is_branch),
        .branched(branched), .valid_inst(valid_inst), .display(display), .pc_dbg(pc_dbg),
        .regfile_data_dbg(regfile_data_dbg), .view_sel(view_sel), .halted(halted0),
        .seg_n(seg0), .an_n(an0)
    );
    laji_stat_display #(.SCAN_DIV(4), .CNT_W(4)) u1 (
        .clk(clk), .rst_n(rst_n), .en(en), .halt(halt), .is_jump(is_jump), .is_branch(is_branch),
        .branched(branched), .valid_inst(valid_inst), .display(display), .pc_dbg(pc_dbg),
        .regfile_data_dbg(regfile_data_dbg), .view_sel(view_sel), .halted(halted1),
        .seg_n(seg1), .an_n(an1)
    );
    assign seg_m = use1 ? seg1 : seg0;
    assign an_m  = use1 ? an1 : an0;
    always #5 clk = ~clk;
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask
    function automatic logic [3:0] dec(input logic [6:0] s);
        logic [3:0] r;
        r = 'x;
        for (int i = 0; i < 16; i++) if (SEGT[i] == s) r = 4'(i);
        return r;
    endfunction
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask
    // waits for a fresh frame, then captures all 8 digits, checking digit enables and dp
    task automatic read_frame(input bit exp_halt, output logic [31:0] val, output logic [63:0] sg);
        int n;
        logic [7:0] an_exp;
        n = 0;
        @(negedge clk);
        while (an_m !== 8'h7F && n < 64) begin @(negedge clk); n++; end
        while (an_m !== 8'hFE && n < 64) begin @(negedge clk); n++; end
        check("scan_timeout", 32'(n >= 64), 32'd0);
        for (int k = 0; k < 8; k++) begin
            an_exp = ~(8'b1 << k);
            check($sformatf("an_n_digit%0d", k), 32'(an_m), 32'(an_exp));
            check($sformatf("dp_digit%0d", k), 32'(seg_m[7]), 32'(!(exp_halt && k == 0)));
            val[4*k +: 4] = dec(seg_m[6:0]);
            sg[8*k +: 8]  = seg_m;
            @(negedge clk);
            @(negedge clk);
        end
    endtask
    task automatic expect_view(input bit u, input bit h, input logic [2:0] s, input logic [31:0] val);
        exp_t e;
        e.use1 = u;
        e.hlt  = h;
        e.sel  = s;
        e.val  = val;
        exp_q.push_back(e);
    endtask
    task automatic drain();
        exp_t e;
        logic [31:0] got;
        logic [63:0] sg;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            use1 = e.use1;
            view_sel = e.sel;
            read_frame(e.hlt, got, sg);
            check($sformatf("view%0d_u%0d", e.sel, e.use1), got, e.val);
        end
        use1 = 0;
    endtask
    task automatic do_reset();
        @(negedge clk);
        rst_n = 0;
        en = 0; halt = 0; is_jump = 0; is_branch = 0; branched = 0; valid_inst = 0;
        @(negedge clk);
        rst_n = 1;
    endtask
    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
    initial begin
        // reset values
        step(2);
        check("rst_an_n", 32'(an0), 32'hFE);
        check("rst_seg_n", 32'(seg0), 32'hC0);
        check("rst_halted", 32'(halted0), 0);
        @(negedge clk);
        rst_n = 1;
        // 10 live cycles with no status events
        en = 1;
        step(10);
        en = 0;
        check("halted_idle", 32'(halted0), 0);
        expect_view(0, 0, 3'd1, 32'd10);
        expect_view(0, 0, 3'd2, 32'd0);
        expect_view(0, 0, 3'd3, 32'd0);
        expect_view(0, 0, 3'd4, 32'd0);
        expect_view(0, 0, 3'd5, 32'd0);
        expect_view(0, 0, 3'd7, 32'h0BADF00D);
        drain();
        view_sel = 0;
        read_frame(0, v, segs);
        check("display_word", v, 32'h1234ABCD);
        check("digit0_seg", 32'(segs[7:0]), 32'hA1);
        check("digit7_seg", 32'(segs[63:56]), 32'hF9);
        // en toggling, then halt, then frozen
        do_reset();
        for (int i = 0; i < 8; i++) begin
            en = (i % 2 == 0);
            valid_inst = 1;
            step(1);
        end
        check("pre_halt", 32'(halted0), 0);
        en = 1; halt = 1; valid_inst = 0;
        step(1);
        check("halt_set", 32'(halted0), 1);
        halt = 0; valid_inst = 1; is_jump = 1;
        step(20);
        en = 0; valid_inst = 0; is_jump = 0;
        check("halt_sticky", 32'(halted0), 1);
        expect_view(0, 1, 3'd1, 32'd5);
        expect_view(0, 1, 3'd5, 32'd4);
        expect_view(0, 1, 3'd2, 32'd0);
        drain();
        // branch, taken, jump accounting
        do_reset();
        en = 1;
        for (int i = 0; i < 6; i++) begin
            is_branch = 1;
            branched = (i % 2 == 0);
            step(1);
        end
        is_branch = 0; branched = 1;
        step(1);
        branched = 0; is_jump = 1;
        step(2);
        is_jump = 0; en = 0;
        expect_view(0, 0, 3'd3, 32'd6);
        expect_view(0, 0, 3'd4, 32'd3);
        expect_view(0, 0, 3'd2, 32'd2);
        expect_view(0, 0, 3'd1, 32'd9);
        expect_view(1, 0, 3'd1, 32'd9);
        drain();
        // view change mid-frame must not tear the digits
        view_sel = 0;
        read_frame(0, v, segs);
        begin
            int n;
            logic [15:0] hi;
            n = 0;
            while (an0 !== 8'hEF && n < 64) begin @(negedge clk); n++; end
            check("midframe_timeout", 32'(n >= 64), 0);
            view_sel = 6;
            for (int k = 4; k < 8; k++) begin
                hi[4*(k-4) +: 4] = dec(seg0[6:0]);
                @(negedge clk);
                @(negedge clk);
            end
            check("no_tear", 32'(hi), 32'h1234);
        end
        read_frame(0, v, segs);
        check("after_frame_end", v, 32'h89ABCDEF);
        // saturation of the narrow counters
        do_reset();
        en = 1;
        step(20);
        en = 0;
        expect_view(1, 0, 3'd1, 32'hF);
        expect_view(0, 0, 3'd1, 32'd20);
        drain();
        // asynchronous reset in the middle of a frame
        en = 1;
        begin
            int n;
            n = 0;
            @(negedge clk);
            while (an0 !== 8'hDF && n < 64) begin @(negedge clk); n++; end
            check("async_sync_timeout", 32'(n >= 64), 0);
        end
        #2 rst_n = 0;
        #1;
        check("async_an_n", 32'(an0), 32'hFE);
        check("async_seg_n", 32'(seg0), 32'hC0);
        check("async_an_n_u1", 32'(an1), 32'hFE);
        check("async_halted", 32'(halted0), 0);
        en = 0;
        @(negedge clk);
        rst_n = 1;
        expect_view(0, 0, 3'd1, 32'd0);
        expect_view(1, 0, 3'd1, 32'd0);
        drain();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
